wmem_load_ctrl: RTL
===================

# wmem_load_ctrl

Weight-memory load controller and port arbiter for the matrix-vector multiplier. It accepts an M×N weight matrix as a row-major valid/ready word stream and scatters rows across P weight-memory banks, so lane b holds rows b, b+P, b+2P, … . It then arbitrates bank access between reloading and the compute sequencer, which must hold a read grant while it runs a pass.

## Interface
- M, 13, matrix rows
- N, 16, matrix columns / vector length
- P, 1, number of banks/lanes; 1 ≤ P ≤ M
- WIDTH, 16, weight word width
- ADDRW, 8, bank address width; must be ≥ $clog2(ceil(M/P)*N)

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  request to (re)load a matrix
- w_in  in  WIDTH  weight word
- w_valid  in  1  w_in valid
- w_ready  out  1  controller accepts w_in
- wr_data  out  WIDTH  bank write data, shared by all banks
- wr_addr  out  ADDRW  bank write address
- wr_en  out  P  one-hot bank write enable
- busy  out  1  load in progress
- loaded  out  1  a complete matrix is resident
- done  out  1  one-cycle pulse at load completion
- rd_req  in  1  compute sequencer requests the banks
- rd_gnt  out  1  banks granted to compute
- abort  in  1  present only with WLOAD_ABORT_EN

## Operation
- States: IDLE, LOAD, LOADED, GRANT.
- Reset: the FSM goes to IDLE and all counters and pending_start clear. Output values under reset: w_ready=0, wr_en=0, busy=0, loaded=0, done=0, rd_gnt=0, wr_addr=0.
- Reset mid-load behaves identically: bank contents are partial and undefined, and loaded stays 0.
- IDLE:
  - start → LOAD.
  - rd_req is never granted in IDLE.
- LOAD:
  - busy=1 and w_ready=1.
  - A word is accepted when w_valid&&w_ready. For an accepted word: wr_data=w_in, wr_en[bank]=1, wr_addr=group*N+col. All three are combinational from the handshake.
  - Counters advance on each accept. col 0..N-1. On col wrap, row is incremented and bank is incremented. When bank wraps from P-1 to 0, group is incremented.
  - The accept at row=M-1, col=N-1 is the final word. On that cycle the FSM goes to LOADED and the counters clear. done is registered and pulses high for the next cycle.
  - start is ignored in LOAD.
- LOADED:
  - loaded=1.
  - rd_req with no pending_start → GRANT.
  - start with rd_req low → LOAD; loaded drops to 0 on entry.
  - start and rd_req in the same cycle → GRANT, and pending_start is set (compute wins).
- GRANT:
  - rd_gnt=1 and loaded=1.
  - start sets pending_start.
  - When rd_req drops: if pending_start is set → LOAD and pending_start clears; otherwise → LOADED.
  - A pending start always beats a new rd_req after a release, so reloads cannot be starved.
- wr_en is never asserted outside LOAD, so writes and compute grants are mutually exclusive.

## Timing
- Write latency is zero: the bank write happens on the same edge as the handshake.
- done asserts exactly 1 cycle after the final accept, together with loaded=1.
- rd_gnt rises 1 cycle after rd_req is sampled in LOADED. It falls 1 cycle after rd_req is sampled low.
- With w_valid held high, M*N words load in M*N consecutive cycles.
- Minimum start→first accept is 1 cycle (w_ready rises the cycle after start is sampled in IDLE or LOADED).

## Configuration
- WLOAD_ABORT_EN defined:
  - The abort port exists. In LOAD, abort=1 forces w_ready=0 and wr_en=0 combinationally. The next state is IDLE, counters clear, loaded=0, and done does not pulse.
  - abort is ignored in every other state.
- WLOAD_ABORT_EN undefined: the port is absent, and a load only ends by completion or reset.

## Test plan
- M=3, N=4, P=2, 12 words 1..12 with w_valid always high → bank0 gets 1–4 at addr 0–3 and 9–12 at addr 4–7; bank1 gets 5–8 at addr 0–3. done pulses 1 cycle after the 12th accept; busy is high for 12 cycles.
- Same load with w_valid toggling every other cycle → identical bank contents; no write on invalid cycles; done 1 cycle after the final accept.
- In LOADED, assert start and rd_req together → rd_gnt=1 next cycle, no writes. When rd_req drops → LOAD next cycle with loaded=0, and rd_req re-asserted that cycle is not granted.
- Assert reset after 5 accepts → all outputs 0 on the next cycle and state IDLE. A new start then restarts at addr 0, bank 0.
- start pulsed during LOAD at word 6 → ignored: exactly one done, and the total accept count equals M*N.
- WLOAD_ABORT_EN, abort at word 7 → w_ready=0 that cycle, IDLE next cycle, loaded=0, no done. A subsequent full load completes normally.

Source files
------------

// File: rtl/wmem_load_ctrl.sv
// Weight-memory load controller: scatters a row-major M x N word stream across P banks
// and arbitrates bank access with the compute sequencer. Optional abort port: WLOAD_ABORT_EN.
module wmem_load_ctrl #(
    parameter int M     = 13,
    parameter int N     = 16,
    parameter int P     = 1,
    parameter int WIDTH = 16,
    parameter int ADDRW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] w_in,
    input  logic             w_valid,
    output logic             w_ready,
    output logic [WIDTH-1:0] wr_data,
    output logic [ADDRW-1:0] wr_addr,
    output logic [P-1:0]     wr_en,
    output logic             busy,
    output logic             loaded,
    output logic             done,
    input  logic             rd_req,
    output logic             rd_gnt
`ifdef WLOAD_ABORT_EN
    ,
    input  logic             abort
`endif
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = (M > 1) ? $clog2(M) : 1;
    localparam int BW = (P > 1) ? $clog2(P) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        LOADED = 2'd2,
        GRANT  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CW-1:0]    col_r;
    logic [RW-1:0]    row_r;
    logic [BW-1:0]    bank_r;
    logic [ADDRW-1:0] group_r;
    logic             pending_r;
    logic             done_r;
    logic             abort_s;
    logic             accept_s;
    logic             col_wrap_s;
    logic             bank_wrap_s;
    logic             final_s;

`ifdef WLOAD_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    assign col_wrap_s  = (col_r == CW'(N - 1));
    assign bank_wrap_s = (bank_r == BW'(P - 1));
    assign final_s     = accept_s && col_wrap_s && (row_r == RW'(M - 1));
    assign wr_data     = w_in;
    assign done        = done_r && !reset;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a start seen while granted (or at release) defers the reload
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = LOAD;
                else       state_s = IDLE;
            end
            LOAD: begin
                if (abort_s)      state_s = IDLE;
                else if (final_s) state_s = LOADED;
                else              state_s = LOAD;
            end
            LOADED: begin
                if (rd_req)     state_s = GRANT;
                else if (start) state_s = LOAD;
                else            state_s = LOADED;
            end
            GRANT: begin
                if (!rd_req) begin
                    if (pending_r || start) state_s = LOAD;
                    else                    state_s = LOADED;
                end else begin
                    state_s = GRANT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Status and handshake outputs, forced low while reset is asserted
    always_comb begin
        w_ready  = 1'b0;
        busy     = 1'b0;
        loaded   = 1'b0;
        rd_gnt   = 1'b0;
        accept_s = 1'b0;
        if (!reset) begin
            case (state_r)
                LOAD: begin
                    busy     = 1'b1;
                    w_ready  = !abort_s;
                    accept_s = w_valid && !abort_s;
                end
                LOADED: loaded = 1'b1;
                GRANT: begin
                    loaded = 1'b1;
                    rd_gnt = 1'b1;
                end
                default: busy = 1'b0;
            endcase
        end else begin
            accept_s = 1'b0;
        end
    end

    // Bank write port, live only on the accepting cycle
    always_comb begin
        wr_en   = '0;
        wr_addr = '0;
        for (int i = 0; i < P; i++) begin
            wr_en[i] = accept_s && (bank_r == BW'(i));
        end
        if (accept_s) begin
            wr_addr = group_r * ADDRW'(N) + ADDRW'(col_r);
        end else begin
            wr_addr = '0;
        end
    end

    // Column/row/bank/group counters walk the row-major stream
    always_ff @(posedge clk) begin
        if (reset || (state_r != LOAD) || abort_s || final_s) begin
            col_r   <= '0;
            row_r   <= '0;
            bank_r  <= '0;
            group_r <= '0;
        end else if (accept_s) begin
            if (col_wrap_s) begin
                col_r <= '0;
                row_r <= row_r + RW'(1);
                if (bank_wrap_s) begin
                    bank_r  <= '0;
                    group_r <= group_r + ADDRW'(1);
                end else begin
                    bank_r <= bank_r + BW'(1);
                end
            end else begin
                col_r <= col_r + CW'(1);
            end
        end else begin
            col_r <= col_r;
        end
    end

    // Deferred reload request and completion pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= final_s;
            case (state_r)
                LOADED: pending_r <= start && rd_req;
                GRANT: begin
                    if (!rd_req)    pending_r <= 1'b0;
                    else if (start) pending_r <= 1'b1;
                    else            pending_r <= pending_r;
                end
                default: pending_r <= 1'b0;
            endcase
        end
    end

endmodule
